// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV64I decode stage: operand fetch/bypass, immediates, load-use stall, ID/EX register
module decode_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_ready,
  input  logic            flush,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic            ex_rd_we,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic [6:0]      ex_funct7,
  output logic            ex_is_load,
  output logic            ex_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic            use_rs1;
  logic            use_rs2;
  logic            legal;
  logic            rd_we_dec;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            stall;
  logic            advance;

  assign opcode   = if_instr[6:0];
  assign rd       = if_instr[11:7];
  assign rs1_addr = if_instr[19:15];
  assign rs2_addr = if_instr[24:20];

  always_comb begin
    imm     = '0;
    legal   = 1'b1;
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        imm     = {{(XLEN-32){if_instr[31]}}, if_instr[31:12], 12'b0};
        use_rs1 = 1'b0;
      end
      OP_JAL: begin
        imm     = {{(XLEN-20){if_instr[31]}}, if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
        use_rs1 = 1'b0;
      end
      OP_JALR, OP_LOAD, OP_IMM, OP_IMM32:
        imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
      OP_STORE: begin
        imm     = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
        use_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        imm     = {{(XLEN-12){if_instr[31]}}, if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
        use_rs2 = 1'b1;
      end
      OP_OP, OP_OP32:
        use_rs2 = 1'b1;
      default:
        legal = 1'b0;
    endcase
  end

  assign rd_we_dec = legal && (opcode != OP_BRANCH) && (opcode != OP_STORE) && (rd != 5'd0);

  // The register file writes at the edge, so a same-cycle writeback must be bypassed here.
  function automatic logic [XLEN-1:0] resolve(input logic [4:0] addr, input logic [XLEN-1:0] rf_data);
    if (addr == 5'd0)
      return '0;
    else if (wb_en && (wb_rd == addr))
      return wb_data;
    else
      return rf_data;
  endfunction

  assign rs1_val = resolve(rs1_addr, rs1_data);
  assign rs2_val = resolve(rs2_addr, rs2_data);

  assign stall = ex_valid && ex_is_load && (ex_rd != 5'd0) && if_valid &&
                 ((use_rs1 && (ex_rd == rs1_addr)) || (use_rs2 && (ex_rd == rs2_addr)));
  assign advance  = !ex_valid || ex_ready;
  assign id_ready = flush || (advance && !stall);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_rs1_val <= '0;
      ex_rs2_val <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_imm     <= '0;
      ex_rd      <= '0;
      ex_rd_we   <= 1'b0;
      ex_opcode  <= '0;
      ex_funct3  <= '0;
      ex_funct7  <= '0;
      ex_is_load <= 1'b0;
      ex_illegal <= 1'b0;
    end else if (flush || (advance && stall)) begin
      // Flush and bubble only invalidate; payload fields are left as they were.
      ex_valid <= 1'b0;
    end else if (advance) begin
      ex_valid   <= if_valid;
      ex_pc      <= if_pc;
      ex_rs1_val <= rs1_val;
      ex_rs2_val <= rs2_val;
      ex_rs1     <= rs1_addr;
      ex_rs2     <= rs2_addr;
      ex_imm     <= imm;
      ex_rd      <= rd;
      ex_rd_we   <= rd_we_dec;
      ex_opcode  <= opcode;
      ex_funct3  <= if_instr[14:12];
      ex_funct7  <= if_instr[31:25];
      ex_is_load <= (opcode == OP_LOAD);
      ex_illegal <= !legal;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        id_ready;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [63:0] rs1_data, rs2_data;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        ex_ready;
  logic        flush;
  logic        ex_valid;
  logic [63:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_rd_we;
  logic [6:0]  ex_opcode, ex_funct7;
  logic [2:0]  ex_funct3;
  logic        ex_is_load, ex_illegal;

  decode_stage #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_ready(ex_ready), .flush(flush), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_opcode(ex_opcode),
    .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_is_load(ex_is_load), .ex_illegal(ex_illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] r1;
    logic [63:0] r2;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic [63:0] imm;
    logic [63:0] v1;
    logic [63:0] v2;
    logic        rd_we;
    logic        is_load;
    logic        illegal;
  } vec_t;

  vec_t vecs[13];
  vec_t sb[$];
  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input logic [31:0] instr, input logic [63:0] pc,
                              input logic [63:0] r1, input logic [63:0] r2,
                              input logic wbe, input logic [4:0] wbr, input logic [63:0] wbd,
                              input logic [63:0] imm, input logic [63:0] v1, input logic [63:0] v2,
                              input logic rd_we, input logic is_load, input logic illegal);
    vec_t v;
    v.instr = instr; v.pc = pc; v.r1 = r1; v.r2 = r2;
    v.wb_en = wbe; v.wb_rd = wbr; v.wb_data = wbd;
    v.imm = imm; v.v1 = v1; v.v2 = v2;
    v.rd_we = rd_we; v.is_load = is_load; v.illegal = illegal;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    if_valid = 1'b1;
    if_instr = v.instr;
    if_pc    = v.pc;
    rs1_data = v.r1;
    rs2_data = v.r2;
    wb_en    = v.wb_en;
    wb_rd    = v.wb_rd;
    wb_data  = v.wb_data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_entry();
    vec_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: ex_valid=1 but no expected entry queued");
    end else begin
      e = sb.pop_front();
      check("ex_pc", ex_pc, e.pc);
      check("ex_imm", ex_imm, e.imm);
      check("ex_rs1_val", ex_rs1_val, e.v1);
      check("ex_rs2_val", ex_rs2_val, e.v2);
      check("ex_rd", {59'd0, ex_rd}, {59'd0, e.instr[11:7]});
      check("ex_rs1", {59'd0, ex_rs1}, {59'd0, e.instr[19:15]});
      check("ex_rs2", {59'd0, ex_rs2}, {59'd0, e.instr[24:20]});
      check("ex_opcode", {57'd0, ex_opcode}, {57'd0, e.instr[6:0]});
      check("ex_funct3", {61'd0, ex_funct3}, {61'd0, e.instr[14:12]});
      check("ex_funct7", {57'd0, ex_funct7}, {57'd0, e.instr[31:25]});
      check("ex_rd_we", {63'd0, ex_rd_we}, {63'd0, e.rd_we});
      check("ex_is_load", {63'd0, ex_is_load}, {63'd0, e.is_load});
      check("ex_illegal", {63'd0, ex_illegal}, {63'd0, e.illegal});
    end
  endtask

  // Drive one instruction expected to be accepted, then compare it when it appears on ID/EX.
  task automatic issue(input string tag, input vec_t v);
    drive(v);
    #1;
    check({tag, "_id_ready"}, {63'd0, id_ready}, 64'd1);
    check({tag, "_rs1_addr"}, {59'd0, rs1_addr}, {59'd0, v.instr[19:15]});
    check({tag, "_rs2_addr"}, {59'd0, rs2_addr}, {59'd0, v.instr[24:20]});
    sb.push_back(v);
    tick();
    check({tag, "_ex_valid"}, {63'd0, ex_valid}, 64'd1);
    compare_entry();
  endtask

  localparam logic [63:0] R1 = 64'h1111;
  localparam logic [63:0] R2 = 64'h2222;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  vec_t v_ld7, v_add_dep, v_ld0, v_add0, v_addi, v_lui, v_beq;

  initial begin
    vecs[0]  = mk(32'hFFF00293, 64'h1000, R1, R2, 1'b0, 5'd0, 64'h0,     ONES,                  64'h0,    R2,       1, 0, 0);
    vecs[1]  = mk(32'h002081B3, 64'h1004, R1, 64'h2, 1'b1, 5'd2, 64'hABCD, 64'h0,                R1,       64'hABCD, 1, 0, 0);
    vecs[2]  = mk(32'h002101B3, 64'h1008, R1, R2, 1'b1, 5'd2, 64'h5555,  64'h0,                  64'h5555, 64'h5555, 1, 0, 0);
    vecs[3]  = mk(32'h00100233, 64'h100C, R1, R2, 1'b1, 5'd0, 64'h77,    64'h0,                  64'h0,    R2,       1, 0, 0);
    vecs[4]  = mk(32'h12345537, 64'h1010, R1, R2, 1'b0, 5'd0, 64'h0,     64'h0000_0000_1234_5000, R1,      R2,       1, 0, 0);
    vecs[5]  = mk(32'h00513423, 64'h1014, R1, R2, 1'b0, 5'd0, 64'h0,     64'h8,                  R1,       R2,       0, 0, 0);
    vecs[6]  = mk(32'hFE000EE3, 64'h1018, R1, R2, 1'b0, 5'd0, 64'h0,     64'hFFFF_FFFF_FFFF_FFFC, 64'h0,   64'h0,    0, 0, 0);
    vecs[7]  = mk(32'hFF9FF0EF, 64'h101C, R1, R2, 1'b0, 5'd0, 64'h0,     64'hFFFF_FFFF_FFFF_FFF8, R1,      R2,       1, 0, 0);
    vecs[8]  = mk(32'h80000117, 64'h1020, R1, R2, 1'b0, 5'd0, 64'h0,     64'hFFFF_FFFF_8000_0000, 64'h0,   64'h0,    1, 0, 0);
    vecs[9]  = mk(32'h00008067, 64'h1024, R1, R2, 1'b0, 5'd0, 64'h0,     64'h0,                  R1,       64'h0,    0, 0, 0);
    vecs[10] = mk(32'h0000B383, 64'h1028, R1, R2, 1'b0, 5'd0, 64'h0,     64'h0,                  R1,       64'h0,    1, 1, 0);
    vecs[11] = mk(32'h000002FF, 64'h102C, R1, R2, 1'b0, 5'd0, 64'h0,     64'h0,                  64'h0,    64'h0,    0, 0, 1);
    vecs[12] = mk(32'h8003031B, 64'h1030, R1, R2, 1'b0, 5'd0, 64'h0,     64'hFFFF_FFFF_FFFF_F800, R1,      64'h0,    1, 0, 0);

    v_ld7     = mk(32'h0000B383, 64'h2000, R1, R2, 1'b0, 5'd0, 64'h0, 64'h0, R1,    64'h0, 1, 1, 0);
    v_add_dep = mk(32'h00738433, 64'h2004, R1, R2, 1'b0, 5'd0, 64'h0, 64'h0, R1,    R2,    1, 0, 0);
    v_ld0     = mk(32'h0000B003, 64'h2008, R1, R2, 1'b0, 5'd0, 64'h0, 64'h0, R1,    64'h0, 0, 1, 0);
    v_add0    = mk(32'h00000433, 64'h200C, R1, R2, 1'b0, 5'd0, 64'h0, 64'h0, 64'h0, 64'h0, 1, 0, 0);
    v_addi    = vecs[0];
    v_lui     = vecs[4];
    v_beq     = vecs[6];

    rst_n = 1'b0; if_valid = 1'b0; if_instr = 32'h0; if_pc = 64'h0;
    rs1_data = R1; rs2_data = R2; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 64'h0;
    ex_ready = 1'b1; flush = 1'b0;
    repeat (2) tick();
    check("rst_ex_valid", {63'd0, ex_valid}, 64'd0);
    check("rst_ex_imm", ex_imm, 64'd0);
    check("rst_ex_pc", ex_pc, 64'd0);
    check("rst_ex_rd_we", {63'd0, ex_rd_we}, 64'd0);
    check("rst_id_ready", {63'd0, id_ready}, 64'd1);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) issue($sformatf("vec%0d", i), vecs[i]);

    // Load-use: one bubble, then the dependent ADD issues.
    issue("ld7", v_ld7);
    drive(v_add_dep);
    #1;
    check("stall_id_ready", {63'd0, id_ready}, 64'd0);
    tick();
    check("bubble_ex_valid", {63'd0, ex_valid}, 64'd0);
    issue("add_after_bubble", v_add_dep);

    // Load to x0 must not stall a consumer of x0.
    issue("ld_x0", v_ld0);
    issue("add_x0", v_add0);

    // Back-pressure for three cycles, then release.
    issue("bp_head", v_addi);
    ex_ready = 1'b0;
    drive(v_lui);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_id_ready", {63'd0, id_ready}, 64'd0);
      tick();
      check("bp_ex_valid", {63'd0, ex_valid}, 64'd1);
      check("bp_ex_imm", ex_imm, ONES);
      check("bp_ex_rd", {59'd0, ex_rd}, 64'd5);
    end
    ex_ready = 1'b1;
    issue("bp_release", v_lui);

    // Flush with a valid stalled entry downstream.
    ex_ready = 1'b0;
    drive(v_addi);
    flush = 1'b1;
    #1;
    check("flush_id_ready", {63'd0, id_ready}, 64'd1);
    tick();
    check("flush_ex_valid", {63'd0, ex_valid}, 64'd0);
    flush = 1'b0;
    ex_ready = 1'b1;
    issue("beq_after_flush", v_beq);

    // Reset asserted while a load-use stall is pending.
    issue("ld7_rst", v_ld7);
    drive(v_add_dep);
    #1;
    check("rst_stall_id_ready", {63'd0, id_ready}, 64'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ex_valid", {63'd0, ex_valid}, 64'd0);
    check("rst_mid_ex_rd", {59'd0, ex_rd}, 64'd0);
    check("rst_mid_ex_is_load", {63'd0, ex_is_load}, 64'd0);
    check("rst_mid_id_ready", {63'd0, id_ready}, 64'd1);
    if_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    check("post_rst_ex_valid", {63'd0, ex_valid}, 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage of the RV64I pipeline, placed between the IF/ID register and the execute stage. It drives the two register-file read addresses from the incoming instruction and applies writeback bypass and x0 masking to the returned operands. It generates the sign-extended immediate and detects load-use hazards, and it holds everything in the ID/EX pipeline register behind a valid/ready handshake with flush support.

## Interface
- XLEN, 64, datapath and PC width
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  IF/ID holds a valid instruction
- if_instr  in  32  instruction word
- if_pc  in  XLEN  PC of if_instr
- id_ready  out  1  decode accepts if_instr this cycle (combinational)
- rs1_addr  out  5  register-file read port 1 address, = if_instr[19:15] (combinational)
- rs2_addr  out  5  register-file read port 2 address, = if_instr[24:20] (combinational)
- rs1_data  in  XLEN  register-file read data 1 (asynchronous read)
- rs2_data  in  XLEN  register-file read data 2
- wb_en  in  1  writeback stage writes register file this cycle
- wb_rd  in  5  writeback destination
- wb_data  in  XLEN  writeback data
- ex_ready  in  1  execute stage consumes the ID/EX entry this cycle
- flush  in  1  branch/jump redirect; kills decode and ID/EX contents
- ex_valid  out  1  ID/EX entry valid
- ex_pc  out  XLEN  PC of the entry
- ex_rs1_val, ex_rs2_val  out  XLEN each  resolved source operands
- ex_rs1, ex_rs2  out  5 each  source register numbers, for downstream forwarding
- ex_imm  out  XLEN  sign-extended immediate
- ex_rd  out  5  destination register
- ex_rd_we  out  1  entry writes rd (0 when rd = x0)
- ex_opcode  out  7 / ex_funct3  out  3 / ex_funct7  out  7  raw decode fields
- ex_is_load  out  1  opcode = 0000011
- ex_illegal  out  1  opcode not in the supported RV64I set

## Operation
- Supported opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP-IMM-32 0011011, OP 0110011, OP-32 0111011. Any other opcode sets ex_illegal=1 and ex_rd_we=0; the entry still flows.
- Immediates, sign-extended from instr[31] to XLEN:
  - I-type: JALR, LOAD, OP-IMM, OP-IMM-32 use instr[31:20].
  - S-type: {instr[31:25], instr[11:7]}.
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U-type: {instr[31:12], 12'b0}.
  - J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - R-type: immediate = 0.
- Source use:
  - rs1 is used by every opcode except LUI, AUIPC and JAL.
  - rs2 is used by BRANCH, STORE, OP and OP-32.
  - ex_rd_we = 1 for all opcodes except BRANCH and STORE, and only when rd != 0.
- Operand resolution, per port:
  - Address 0 gives 0.
  - Otherwise, if wb_en=1 and wb_rd equals the address, the operand is wb_data (bypass; the register file write lands only at the edge).
  - Otherwise the operand is rs*_data.
- Load-use stall: raised when ex_valid=1, ex_is_load=1, ex_rd != 0, and ex_rd equals a *used* source of if_instr while if_valid=1. Downstream forwarding from MEM/WB covers the remaining hazards.
- Handshake:
  - advance = !ex_valid | ex_ready.
  - id_ready = flush | (advance & !stall).
  - The instruction is consumed when if_valid & id_ready.
- ID/EX update, in priority order:
  1. flush=1: ex_valid <= 0 and the decoded instruction is discarded.
  2. Else advance & stall: insert a bubble, ex_valid <= 0.
  3. Else advance: ex_valid <= if_valid and all ex_* fields are loaded.
  4. Else: hold all fields.

## Timing
- Reset (rst_n=0, asynchronous): ex_valid=0 and every ex_* output = 0. id_ready follows its equation, so it is 1 when flush=0 and no stall is present.
- Decode latency is 1 cycle: an instruction accepted at edge N appears on ex_* after edge N.
- The load-use stall lasts exactly 1 cycle when ex_ready=1. After the bubble, ex_is_load=0, so the instruction is accepted on the next edge.
- ex_ready=0 with ex_valid=1: all ex_* fields are stable and id_ready=0 (back-pressure).
- A bubble never clears fields other than ex_valid. ex_* contents are don't-care while ex_valid=0.
- Reset asserted mid-stall or mid-back-pressure returns the block to the reset state immediately; no instruction is retained.
- Same-cycle wb_rd matching both rs1 and rs2: both operands take wb_data.

## Test plan
- Reset, then ADDI x5,x0,-1 (0xFFF00293) with ex_ready=1 -> next cycle ex_valid=1, ex_imm=0xFFFFFFFFFFFFFFFF, ex_rd=5, ex_rd_we=1, ex_rs1_val=0.
- ADD x3,x1,x2 while wb_en=1, wb_rd=2, wb_data=0xABCD, rs2_data=2 -> ex_rs2_val=0xABCD, ex_rs1_val=rs1_data.
- LD x7,0(x1) followed by ADD x8,x7,x7 -> one bubble cycle (ex_valid=0, id_ready=0 for 1 cycle), then the ADD issues. With rd=x0 on the load, there is no stall.
- ex_ready=0 for 3 cycles with a valid entry -> id_ready=0, outputs unchanged. On release, the next instruction loads on the following edge.
- flush=1 while if_valid=1 and ex_valid=1 -> id_ready=1 and ex_valid=0 after the edge. A BEQ with offset -4 (0xFE000EE3) then gives ex_imm=0xFFFFFFFFFFFFFFFC.
- Opcode 0x7F -> ex_illegal=1 and ex_rd_we=0. Also assert rst_n low mid-stall -> ex_valid=0 immediately.
